// File: rtl/chiplet_types_pkg.sv
// Shared types and constants for the endpoint receive path.
package chiplet_types_pkg;

  localparam int PKT_LENGTH_WIDTH = 8;
  localparam int META_VC_W        = 4;
  localparam int META_IDX_W       = 16;

  localparam logic [31:0] CRC32_POLY = 32'hEDB88320;  // reflected 0x04C11DB7
  localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BODY,
    ST_CRC,
    ST_COMMIT,
    ST_DROP
  } rx_state_e;

  typedef struct packed {
    logic [4:0]                  id;
    logic [1:0]                  req;
    logic [META_VC_W-1:0]        vc;
    logic [META_IDX_W-1:0]       start_idx;
    logic [PKT_LENGTH_WIDTH-1:0] body_len;
  } rx_meta_t;

  function automatic logic [PKT_LENGTH_WIDTH-1:0] body_words(input logic [31:0] hdr);
    return hdr[PKT_LENGTH_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/rx_crc32_word.sv
// Reflected CRC-32 accumulator folding one DW-bit word per cycle, LSB first.
module rx_crc32_word
  import chiplet_types_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          clr_i,
  input  logic          upd_i,
  input  logic [DW-1:0] data_i,
  output logic [31:0]   crc_o
);

  logic [31:0] acc_q, acc_d;

  // clr_i together with upd_i folds the word into a fresh seed.
  always_comb begin
    acc_d = clr_i ? CRC32_INIT : acc_q;
    if (upd_i) begin
      for (int i = 0; i < DW; i++) begin
        acc_d = (acc_d >> 1) ^ ((acc_d[0] ^ data_i[i]) ? CRC32_POLY : 32'h0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (n_rst) acc_q <= CRC32_INIT;
    else if (clr_i || upd_i) acc_q <= acc_d;
  end

  assign crc_o = ~acc_q;

endmodule

// File: rtl/rx_fsm_mvc.sv
// Endpoint receive FSM: CRC-checked flits into a ring buffer, per-VC credits,
// descriptor push on commit. DATA_WIDTH must be at least 32.
module rx_fsm_mvc
  import chiplet_types_pkg::*;
#(
  parameter  int NUM_VC         = 2,
  parameter  int DATA_WIDTH     = 32,
  parameter  int BUF_WORDS      = 512,
  parameter  int MAX_BODY_WORDS = 128,
  parameter  int CNT_WIDTH      = 16,
  localparam int VC_W           = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
  localparam int AW             = $clog2(BUF_WORDS)
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  flit_valid,
  output logic                  flit_ready,
  input  logic [VC_W-1:0]       flit_vc,
  input  logic [4:0]            flit_id,
  input  logic [1:0]            flit_req,
  input  logic [DATA_WIDTH-1:0] flit_payload,
  output logic [NUM_VC-1:0]     credit_granted,
  output logic                  buf_wen,
  output logic [AW-1:0]         buf_waddr,
  output logic [DATA_WIDTH-1:0] buf_wdata,
  input  logic [AW:0]           buf_free_words,
  output logic [AW-1:0]         wptr_commit,
  output logic                  meta_push,
  input  logic                  meta_full,
  output rx_meta_t              meta_data,
  output logic                  crc_error,
  output logic                  len_error,
  output logic                  space_drop,
  output logic [CNT_WIDTH-1:0]  pkt_ok_cnt,
  output logic [CNT_WIDTH-1:0]  pkt_err_cnt
);

  localparam int REM_W = PKT_LENGTH_WIDTH + 1;

  rx_state_e                   state_q, state_d;
  logic [AW-1:0]               wptr_q, wptr_d, wcommit_q, wcommit_d, start_q, start_d;
  logic [VC_W-1:0]             vc_q, vc_d;
  logic [4:0]                  id_q, id_d;
  logic [1:0]                  req_q, req_d;
  logic [PKT_LENGTH_WIDTH-1:0] len_q, len_d, hdr_len;
  logic [REM_W-1:0]            rem_q, rem_d;
  logic [CNT_WIDTH-1:0]        ok_q, ok_d, err_q, err_d;
  logic                        accept, crc_clr, crc_upd, crc_match;
  logic                        ok_inc, err_inc, too_long, no_space;
  logic [31:0]                 crc_val;

  assign flit_ready = !n_rst && (state_q != ST_COMMIT);
  assign accept     = flit_valid && flit_ready;
  assign hdr_len    = body_words(flit_payload[31:0]);
  assign too_long   = int'(hdr_len) > MAX_BODY_WORDS;
  assign no_space   = int'(buf_free_words) < int'(hdr_len) + 1;
  assign crc_match  = flit_payload[31:0] == crc_val;

  rx_crc32_word #(.DW(DATA_WIDTH)) u_crc (
    .clk    (clk),
    .n_rst  (n_rst),
    .clr_i  (crc_clr),
    .upd_i  (crc_upd),
    .data_i (flit_payload),
    .crc_o  (crc_val)
  );

  always_comb begin
    state_d        = state_q;
    wptr_d         = wptr_q;
    wcommit_d      = wcommit_q;
    start_d        = start_q;
    vc_d           = vc_q;
    id_d           = id_q;
    req_d          = req_q;
    len_d          = len_q;
    rem_d          = rem_q;
    ok_d           = ok_q;
    err_d          = err_q;
    credit_granted = '0;
    buf_wen        = 1'b0;
    meta_push      = 1'b0;
    crc_error      = 1'b0;
    len_error      = 1'b0;
    space_drop     = 1'b0;
    crc_clr        = 1'b0;
    crc_upd        = 1'b0;
    ok_inc         = 1'b0;
    err_inc        = 1'b0;

    unique case (state_q)
      ST_IDLE: if (accept) begin
        credit_granted[flit_vc] = 1'b1;
        vc_d    = flit_vc;
        id_d    = flit_id;
        req_d   = flit_req;
        len_d   = hdr_len;
        start_d = wptr_q;
        crc_clr = 1'b1;
        crc_upd = 1'b1;
        if (too_long || no_space) begin
          // Drain body plus CRC flit without touching the ring.
          len_error  = too_long;
          space_drop = !too_long;
          err_inc    = 1'b1;
          rem_d      = REM_W'(hdr_len) + REM_W'(1);
          state_d    = ST_DROP;
        end else begin
          buf_wen = 1'b1;
          wptr_d  = wptr_q + AW'(1);
          rem_d   = REM_W'(hdr_len);
          state_d = (hdr_len == '0) ? ST_CRC : ST_BODY;
        end
      end
      ST_BODY: if (accept) begin
        credit_granted[vc_q] = 1'b1;
        buf_wen = 1'b1;
        crc_upd = 1'b1;
        wptr_d  = wptr_q + AW'(1);
        rem_d   = rem_q - REM_W'(1);
        if (rem_q == REM_W'(1)) state_d = ST_CRC;
      end
      ST_CRC: if (accept) begin
        credit_granted[vc_q] = 1'b1;
        if (crc_match) begin
          state_d = ST_COMMIT;
        end else begin
          crc_error = 1'b1;
          err_inc   = 1'b1;
          wptr_d    = start_q;
          state_d   = ST_IDLE;
        end
      end
      ST_COMMIT: if (!meta_full && !n_rst) begin
        meta_push = 1'b1;
        wcommit_d = wptr_q;
        ok_inc    = 1'b1;
        state_d   = ST_IDLE;
      end
      ST_DROP: if (accept) begin
        credit_granted[vc_q] = 1'b1;
        rem_d = rem_q - REM_W'(1);
        if (rem_q == REM_W'(1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (ok_inc && (ok_q != '1))   ok_d  = ok_q + CNT_WIDTH'(1);
    if (err_inc && (err_q != '1)) err_d = err_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      state_q   <= ST_IDLE;
      wptr_q    <= '0;
      wcommit_q <= '0;
      start_q   <= '0;
      vc_q      <= '0;
      id_q      <= '0;
      req_q     <= '0;
      len_q     <= '0;
      rem_q     <= '0;
      ok_q      <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      wptr_q    <= wptr_d;
      wcommit_q <= wcommit_d;
      start_q   <= start_d;
      vc_q      <= vc_d;
      id_q      <= id_d;
      req_q     <= req_d;
      len_q     <= len_d;
      rem_q     <= rem_d;
      ok_q      <= ok_d;
      err_q     <= err_d;
    end
  end

  assign buf_waddr   = wptr_q;
  assign buf_wdata   = flit_payload;
  assign wptr_commit = wcommit_q;
  assign pkt_ok_cnt  = ok_q;
  assign pkt_err_cnt = err_q;
  assign meta_data   = '{id: id_q, req: req_q, vc: META_VC_W'(vc_q),
                         start_idx: META_IDX_W'(start_q), body_len: len_q};

endmodule

// File: tb/tb_rx_fsm_mvc.sv
// Scoreboarded bench for rx_fsm_mvc: directed corner packets then random traffic.
module tb_rx_fsm_mvc;
  import chiplet_types_pkg::*;

  localparam int NUM_VC = 2, DW = 32, BW = 512, MAXB = 128, CW = 16, VCW = 1, AW = 9;
  localparam int EV_OK = 0, EV_CRC = 1, EV_LEN = 2, EV_SPACE = 3;

  logic           clk = 1'b0, n_rst = 1'b1;
  logic           flit_valid = 1'b0, flit_ready;
  logic [VCW-1:0] flit_vc = '0;
  logic [4:0]     flit_id = '0;
  logic [1:0]     flit_req = '0;
  logic [DW-1:0]  flit_payload = '0;
  logic [NUM_VC-1:0] credit_granted;
  logic           buf_wen, meta_push, meta_full, crc_error, len_error, space_drop;
  logic [AW-1:0]  buf_waddr, wptr_commit;
  logic [DW-1:0]  buf_wdata;
  logic [AW:0]    buf_free_words;
  rx_meta_t       meta_data;
  logic [CW-1:0]  pkt_ok_cnt, pkt_err_cnt;

  logic mf_force = 1'b0, mf_rand = 1'b0, rand_mf = 1'b0;
  int   free_w = 512;
  assign meta_full      = rand_mf ? mf_rand : mf_force;
  assign buf_free_words = free_w[AW:0];

  rx_fsm_mvc #(.NUM_VC(NUM_VC), .DATA_WIDTH(DW), .BUF_WORDS(BW),
               .MAX_BODY_WORDS(MAXB), .CNT_WIDTH(CW)) dut (
    .clk(clk), .n_rst(n_rst), .flit_valid(flit_valid), .flit_ready(flit_ready),
    .flit_vc(flit_vc), .flit_id(flit_id), .flit_req(flit_req), .flit_payload(flit_payload),
    .credit_granted(credit_granted), .buf_wen(buf_wen), .buf_waddr(buf_waddr),
    .buf_wdata(buf_wdata), .buf_free_words(buf_free_words), .wptr_commit(wptr_commit),
    .meta_push(meta_push), .meta_full(meta_full), .meta_data(meta_data),
    .crc_error(crc_error), .len_error(len_error), .space_drop(space_drop),
    .pkt_ok_cnt(pkt_ok_cnt), .pkt_err_cnt(pkt_err_cnt)
  );

  always #10 clk = ~clk;

  typedef struct { int addr; logic [31:0] data; } wr_t;
  typedef struct { int kind; logic [4:0] id; logic [1:0] req; int vc; int start; int len; } ev_t;
  wr_t wq[$];
  ev_t evq[$];
  logic [31:0] fixed_body[$];

  int n_checks = 0, n_fail = 0;
  int m_wptr = 0, m_commit = 0, m_ok = 0, m_err = 0;
  int cred_exp[NUM_VC];
  int cred_cnt[NUM_VC];

  task automatic check(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Byte-serial reflected CRC-32 over the little-endian byte stream of the words.
  function automatic logic [31:0] crc_model(input logic [31:0] w[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (w[k]) begin
      for (int b = 0; b < 4; b++) begin
        c = c ^ {24'h0, w[k][8*b +: 8]};
        repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
    end
    return ~c;
  endfunction

  always @(negedge clk) mf_rand = ($urandom_range(0, 3) == 0);

  // Monitor: sample late in the low phase, well clear of the active edge.
  always @(negedge clk) begin
    wr_t w;
    ev_t e;
    int nflag, akind;
    #5;
    for (int v = 0; v < NUM_VC; v++) if (credit_granted[v]) cred_cnt[v]++;
    if (buf_wen) begin
      if (wq.size() == 0) check("unexpected_write", 1, 0);
      else begin
        w = wq.pop_front();
        check("waddr", buf_waddr, w.addr);
        check("wdata", buf_wdata, w.data);
      end
    end
    nflag = int'(meta_push) + int'(crc_error) + int'(len_error) + int'(space_drop);
    if (nflag > 1) check("multi_event", nflag, 1);
    else if (nflag == 1) begin
      akind = meta_push ? EV_OK : crc_error ? EV_CRC : len_error ? EV_LEN : EV_SPACE;
      if (evq.size() == 0) check("unexpected_event", akind, -1);
      else begin
        e = evq.pop_front();
        check("event_kind", akind, e.kind);
        if (meta_push && e.kind == EV_OK) begin
          check("meta_id", meta_data.id, e.id);
          check("meta_req", meta_data.req, e.req);
          check("meta_vc", meta_data.vc, e.vc);
          check("meta_start", meta_data.start_idx, e.start);
          check("meta_len", meta_data.body_len, e.len);
        end
      end
    end
  end

  task automatic send_pkt(input int vc, input int n, input bit bad, input int limit);
    logic [31:0] fl[$];
    logic [31:0] w;
    logic [4:0]  id;
    logic [1:0]  req;
    int total, nsent, nwr, g;
    bit admit;
    ev_t e;
    id = 5'($urandom);
    req = 2'($urandom);
    w = $urandom;
    w[7:0] = n[7:0];
    fl.push_back(w);
    for (int i = 0; i < n; i++) fl.push_back(fixed_body.size() > 0 ? fixed_body.pop_front() : $urandom);
    w = crc_model(fl);
    if (bad) w[0] = ~w[0];
    fl.push_back(w);
    total = n + 2;
    nsent = (limit < total) ? limit : total;
    admit = (n <= MAXB) && (free_w >= n + 1);
    cred_exp[vc] += nsent;
    if (admit) begin
      nwr = (nsent < n + 1) ? nsent : n + 1;
      for (int i = 0; i < nwr; i++) wq.push_back('{addr: (m_wptr + i) % BW, data: fl[i]});
    end
    if (nsent == total) begin
      e.id = id; e.req = req; e.vc = vc; e.start = m_wptr; e.len = n;
      if (n > MAXB) begin e.kind = EV_LEN; m_err++; end
      else if (!admit) begin e.kind = EV_SPACE; m_err++; end
      else if (bad) begin e.kind = EV_CRC; m_err++; end
      else begin
        e.kind = EV_OK;
        m_wptr = (m_wptr + n + 1) % BW;
        m_commit = m_wptr;
        m_ok++;
      end
      evq.push_back(e);
    end
    for (int k = 0; k < nsent; k++) begin
      @(negedge clk);
      flit_valid = 1'b0;
      repeat ($urandom_range(0, 1)) @(negedge clk);
      flit_valid   = 1'b1;
      flit_payload = fl[k];
      flit_vc      = (k == 0) ? vc[VCW-1:0] : VCW'($urandom);
      flit_id      = (k == 0) ? id : 5'($urandom);
      flit_req     = (k == 0) ? req : 2'($urandom);
      g = 0;
      while (!flit_ready && g < 200) begin @(negedge clk); g++; end
      if (g >= 200) begin
        check("flit_accept_timeout", 0, 1);
        flit_valid = 1'b0;
        return;
      end
      @(posedge clk);
    end
    @(negedge clk);
    flit_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int g;
    g = 0;
    do begin @(negedge clk); #7; g++; end
    while (!(flit_ready && evq.size() == 0 && wq.size() == 0) && g < 300);
    if (g >= 300) check({nm, "_idle_timeout"}, 0, 1);
  endtask

  task automatic check_state(input string nm);
    check({nm, "_commit"}, wptr_commit, m_commit);
    check({nm, "_waddr"}, buf_waddr, m_wptr);
    check({nm, "_ok_cnt"}, pkt_ok_cnt, m_ok);
    check({nm, "_err_cnt"}, pkt_err_cnt, m_err);
    for (int v = 0; v < NUM_VC; v++) check($sformatf("%s_cred_vc%0d", nm, v), cred_cnt[v], cred_exp[v]);
  endtask

  task automatic do_reset();
    check("pending_writes_before_reset", wq.size(), 0);
    @(negedge clk);
    n_rst = 1'b1;
    flit_valid = 1'b0;
    @(negedge clk); #7;
    check("rst_ready", flit_ready, 0);
    check("rst_wen", buf_wen, 0);
    check("rst_push", meta_push, 0);
    @(negedge clk);
    n_rst = 1'b0;
    m_wptr = 0; m_commit = 0; m_ok = 0; m_err = 0;
    wq.delete();
    evq.delete();
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    for (int v = 0; v < NUM_VC; v++) begin cred_exp[v] = 0; cred_cnt[v] = 0; end
    do_reset();
    #7;
    check("reset_ready", flit_ready, 1);
    check_state("reset");

    // Good packet, N=2 on VC1.
    fixed_body = '{32'hA5A5A5A5, 32'h12345678};
    send_pkt(1, 2, 1'b0, 1000);
    wait_idle("good");
    check_state("good");

    // Same packet with a corrupted CRC from a clean pointer.
    do_reset();
    fixed_body = '{32'hA5A5A5A5, 32'h12345678};
    send_pkt(1, 2, 1'b1, 1000);
    wait_idle("crcbad");
    check_state("crcbad");

    // Admission drop: too little free space.
    free_w = 2;
    send_pkt(0, 3, 1'b0, 1000);
    wait_idle("space");
    check_state("space");
    free_w = 512;

    // Length error.
    send_pkt(1, 200, 1'b0, 1000);
    wait_idle("len");
    check_state("len");

    // Advance to 510, then a packet that wraps the ring.
    while (m_wptr != 510) begin
      int need, n;
      need = (510 - m_wptr + BW) % BW;
      n = (need - 1 > MAXB) ? MAXB : need - 1;
      send_pkt($urandom_range(0, 1), n, 1'b0, 1000);
    end
    wait_idle("fill");
    check("fill_waddr", buf_waddr, 510);
    send_pkt(1, 3, 1'b0, 1000);
    wait_idle("wrap");
    check("wrap_commit", wptr_commit, 2);
    check_state("wrap");

    // Metadata backpressure held at COMMIT.
    mf_force = 1'b1;
    send_pkt(0, 1, 1'b0, 1000);
    for (int c = 0; c < 10; c++) begin
      #7;
      check("mf_ready_low", flit_ready, 0);
      check("mf_no_push", meta_push, 0);
      @(negedge clk);
    end
    mf_force = 1'b0;
    #1;
    check("mf_push", meta_push, 1);
    wait_idle("mf");
    check_state("mf");

    // Header-only packet, then reset in the middle of a body.
    send_pkt(1, 0, 1'b0, 1000);
    wait_idle("n0");
    check_state("n0");
    send_pkt(0, 5, 1'b0, 3);
    do_reset();
    #7;
    check("midrst_ready", flit_ready, 1);
    check_state("midrst");

    // Random traffic with random metadata backpressure.
    rand_mf = 1'b1;
    for (int p = 0; p < 150; p++) begin
      int n, sel;
      sel = $urandom_range(0, 99);
      if (sel < 85) n = $urandom_range(0, 12);
      else if (sel < 92) n = $urandom_range(129, 160);
      else n = $urandom_range(13, 128);
      free_w = ($urandom_range(0, 9) == 0) ? $urandom_range(0, n + 1) : 512;
      send_pkt($urandom_range(0, 1), n, ($urandom_range(0, 99) < 15), 1000);
    end
    rand_mf = 1'b0;
    wait_idle("rand");
    check_state("rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_fsm_mvc.md
Name: rx_fsm_mvc

Overview:
- Parametrised next-generation endpoint receive FSM.
- Accepts flits from the switch-side endpoint interface, checks a trailing CRC-32, and writes header and body words into a circular receive buffer.
- Returns per-VC credits and pushes a packet descriptor into a metadata FIFO on successful commit.
- Adds what the previous generation lacks: N virtual channels, ring-buffer wrap, free-space admission, rewind on CRC error, length-error drop, metadata backpressure, and status counters.

Parameters:
- NUM_VC, 2, number of virtual channels; width of credit_granted.
- DATA_WIDTH, 32, flit payload and buffer word width.
- BUF_WORDS, 512, receive ring depth in words; must be a power of 2.
- MAX_BODY_WORDS, 128, largest legal body length; larger headers are length errors.
- CNT_WIDTH, 16, width of the status counters.

Ports:
- clk  in  1  clock
- n_rst  in  1  reset; synchronous, active-high (1 = reset)
- flit_valid  in  1  input flit present
- flit_ready  out  1  flit accepted when valid&&ready
- flit_vc  in  $clog2(NUM_VC)  flit VC
- flit_id  in  5  source id
- flit_req  in  2  request type
- flit_payload  in  DATA_WIDTH  flit word
- credit_granted  out  NUM_VC  one-cycle credit pulse per accepted flit
- buf_wen  out  1  ring write strobe
- buf_waddr  out  $clog2(BUF_WORDS)  ring word index
- buf_wdata  out  DATA_WIDTH  equals flit_payload
- buf_free_words  in  $clog2(BUF_WORDS)+1  free ring words from the consumer
- wptr_commit  out  $clog2(BUF_WORDS)  committed write pointer
- meta_push  out  1  descriptor push
- meta_full  in  1  metadata FIFO full
- meta_data  out  rx_meta_t  {id, req, vc, start_idx, body_len}
- crc_error  out  1  pulse on CRC mismatch
- len_error  out  1  pulse on length violation
- space_drop  out  1  pulse on admission drop
- pkt_ok_cnt, pkt_err_cnt  out  CNT_WIDTH  saturating counters

Behaviour:
- Packet format: header flit, then N body flits, then one CRC flit.
  - N = header[PKT_LENGTH_WIDTH-1:0], via package function body_words().
  - CRC-32 (reflected, init 0xFFFFFFFF, final xor) covers header+body.
  - The CRC flit is never written.
- States: IDLE, BODY, CRC, COMMIT, DROP.
- IDLE:
  - flit_ready=1.
  - On accepted flit: latch vc, id, req, N, and start=wptr. Seed the CRC with the header.
  - If N>MAX_BODY_WORDS: pulse len_error, go to DROP with remaining=N+1 (bounded by the length field).
  - Else if buf_free_words<N+1: pulse space_drop, go to DROP with remaining=N+1.
  - Else: write the header at wptr, wptr++, go to BODY (N>0) or CRC (N==0).
- BODY:
  - flit_ready=1.
  - Each accepted flit: write at wptr, update CRC, wptr++, remaining--.
  - The last body flit goes to CRC.
- CRC:
  - flit_ready=1.
  - On an accepted flit, compare against the CRC result.
  - Match: go to COMMIT.
  - Mismatch: pulse crc_error, wptr := start (rewind), pkt_err_cnt++, go to IDLE.
- COMMIT:
  - flit_ready=0.
  - When !meta_full: meta_push=1, wptr_commit := wptr, pkt_ok_cnt++, go to IDLE.
  - Otherwise hold indefinitely.
- DROP:
  - flit_ready=1; consume remaining flits with no writes.
  - pkt_err_cnt++ on entry. Go to IDLE when remaining hits 0.
- Credits:
  - credit_granted[latched vc] pulses for every accepted flit, including dropped ones.
  - For the header flit, use flit_vc directly.
- Write timing: buf_wen is combinational with the accept, no latency; buf_waddr=wptr.
- Wrap: wptr and buf_waddr increment modulo BUF_WORDS; start_idx may exceed the end index.
- Counters saturate at all-ones.
- Reset (any state, mid-packet included), applied next edge:
  - State IDLE; wptr=wptr_commit=0; counters 0; CRC cleared.
  - All pulses and buf_wen/meta_push are 0; flit_ready=0 while n_rst=1.
- No flit is ever accepted in COMMIT.
- Flit VC changing mid-packet is ignored; the latched VC is used.

Decomposition:
- Package chiplet_types_pkg holds:
  - rx_meta_t
  - body_words()
  - CRC32_POLY, CRC32_INIT
  - rx_state_e
- Sub-module rx_crc32_word: single-cycle combinational CRC-32 word update with registered accumulator; clear/update inputs.

Test Plan:
- Header N=2, body 0xA5A5A5A5, 0x12345678, correct CRC, start wptr=0:
  - Writes at idx 0,1,2; 4 credit pulses on vc1.
  - meta_push with start=0, len=2; wptr_commit=3; pkt_ok_cnt=1.
- Same packet with CRC bit 0 flipped:
  - crc_error pulse; wptr back to 0; no meta_push; pkt_err_cnt=1; 4 credits still returned.
- wptr=510, N=3:
  - Writes at 510, 511, 0, 1; start_idx=510; wptr_commit=2.
- buf_free_words=2, N=3:
  - space_drop; 5 flits consumed with no buf_wen; 5 credits returned; wptr unchanged.
- meta_full held for 10 cycles at COMMIT:
  - flit_ready=0 throughout; push on the cycle meta_full drops.
- N=0 packet; then n_rst=1 asserted mid-BODY of the next packet:
  - Header-only commit with len=0.
  - After reset: state IDLE, wptr=0, counters 0.
